// File: rtl/multiplier_issue_unit_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_issue_unit_pkg
// Definitions shared by the sequential multiplier and its issue front end.
//   OPW     : operand width of the multiplier datapath
//   PW      : product width of the multiplier datapath
//   state_t : issue-unit FSM state encoding (3 bits)
// -----------------------------------------------------------------------------
package multiplier_issue_unit_pkg;

    localparam int unsigned OPW = 8;
    localparam int unsigned PW  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_BUSY  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/multiplier_operand_fifo.sv
// -----------------------------------------------------------------------------
// multiplier_operand_fifo
// Circular-buffer FIFO holding pending operand entries for the issue unit.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_push, i_data : write request and entry to store (ignored when full)
//   i_pop          : read request, advances the head (ignored when empty)
//   o_head         : entry at the head of the queue
//   o_full/o_empty : occupancy flags, decoded from registered pointers only
// -----------------------------------------------------------------------------
module multiplier_operand_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 20
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);

endmodule

// File: rtl/multiplier_issue_unit.sv
// -----------------------------------------------------------------------------
// multiplier_issue_unit
// Operand-side front end for the 8x8 sequential multiplier. Queues operand
// pairs, issues them one at a time over the multiplier's start/ready
// handshake, captures each product and returns it with its tag in order.
//   clk, rst                       : clock, asynchronous active-low reset
//   in_valid/in_ready/in_v1/in_v2/in_tag : operand stream (in_ready = not full)
//   mul_start/mul_v1/mul_v2        : start pulse and held operands to multiplier
//   mul_ready/mul_out              : multiplier idle/done flag and product
//   res_valid/res_ready/res_prod/res_tag : result stream
//   busy                           : FSM not idle or operands still queued
// All outputs are registers or decodes of registered state.
// -----------------------------------------------------------------------------
module multiplier_issue_unit
    import multiplier_issue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_v1,
    input  logic [OPW-1:0]   in_v2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic [OPW-1:0]   mul_v1,
    output logic [OPW-1:0]   mul_v2,
    input  logic             mul_ready,
    input  logic [PW-1:0]    mul_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [PW-1:0]    res_prod,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam int unsigned EW = 2 * OPW + TAG_W;

    state_t           r_state;
    state_t           w_next;
    logic [OPW-1:0]   r_v1;
    logic [OPW-1:0]   r_v2;
    logic [TAG_W-1:0] r_tag;
    logic [PW-1:0]    r_prod;
    logic [TAG_W-1:0] r_res_tag;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic [EW-1:0]    w_head;

    assign w_push = in_valid && !w_full;

    multiplier_operand_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  ({in_v1, in_v2, in_tag}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && mul_ready) begin
                    w_pop  = 1'b1;
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_ARM;
            end
            ST_ARM: begin
                // The multiplier may take several cycles to drop ready.
                if (!mul_ready) begin
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mul_ready) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Popping here lets the next start follow the result handshake
                // with no idle cycle; the multiplier is already idle.
                if (res_ready) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_ISSUE;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1  <= '0;
            r_v2  <= '0;
            r_tag <= '0;
        end else if (w_pop) begin
            {r_v1, r_v2, r_tag} <= w_head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prod    <= '0;
            r_res_tag <= '0;
        end else if (w_capture) begin
            r_prod    <= mul_out;
            r_res_tag <= r_tag;
        end
    end

    assign in_ready  = !w_full;
    assign mul_start = (r_state == ST_ISSUE);
    assign mul_v1    = r_v1;
    assign mul_v2    = r_v2;
    assign res_valid = (r_state == ST_HOLD);
    assign res_prod  = r_prod;
    assign res_tag   = r_res_tag;
    assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_multiplier_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_multiplier_issue_unit
// Directed bench for multiplier_issue_unit with a behavioural sequential
// multiplier: after a start it waits drop_dly cycles, drops ready for a few
// cycles (driving a poison value on mul_out), then raises ready with the
// product.
// -----------------------------------------------------------------------------
module tb_multiplier_issue_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_v1;
    logic [7:0]  in_v2;
    logic [3:0]  in_tag;
    logic        mul_start;
    logic [7:0]  mul_v1;
    logic [7:0]  mul_v2;
    logic        mul_ready;
    logic [15:0] mul_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_prod;
    logic [3:0]  res_tag;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;
    int n_starts;
    int drop_dly;
    int m_phase;
    int m_cnt;
    logic [7:0] m_a;
    logic [7:0] m_b;

    multiplier_issue_unit #(
        .DEPTH (4),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_v1     (in_v1),
        .in_v2     (in_v2),
        .in_tag    (in_tag),
        .mul_start (mul_start),
        .mul_v1    (mul_v1),
        .mul_v2    (mul_v2),
        .mul_ready (mul_ready),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier sharing the reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_ready <= 1'b1;
            mul_out   <= 16'h0000;
            m_phase   <= 0;
            m_cnt     <= 0;
            n_starts  <= 0;
            m_a       <= 8'h00;
            m_b       <= 8'h00;
        end else begin
            if (mul_start) n_starts <= n_starts + 1;
            case (m_phase)
                0: if (mul_start) begin
                    m_a     <= mul_v1;
                    m_b     <= mul_v2;
                    mul_out <= 16'hDEAD;
                    m_cnt   <= drop_dly;
                    m_phase <= 1;
                end
                1: if (m_cnt == 0) begin
                    mul_ready <= 1'b0;
                    m_cnt     <= 3;
                    m_phase   <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (m_cnt == 0) begin
                    mul_ready <= 1'b1;
                    mul_out   <= {8'h00, m_a} * {8'h00, m_b};
                    m_phase   <= 0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({nm, "_mul_start"}, {31'd0, mul_start}, 32'd0);
        check({nm, "_mul_v1"},    {24'd0, mul_v1},    32'd0);
        check({nm, "_mul_v2"},    {24'd0, mul_v2},    32'd0);
        check({nm, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({nm, "_res_prod"},  {16'd0, res_prod},  32'd0);
        check({nm, "_res_tag"},   {28'd0, res_tag},   32'd0);
        check({nm, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        int n;
        n = 0;
        in_v1 = a; in_v2 = b; in_tag = t; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("push_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm);
        int n;
        n = 0;
        while (!res_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_valid"}, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic get(input logic [15:0] ep, input logic [3:0] et, input string nm);
        wait_res(nm);
        check({nm, "_prod"}, {16'd0, res_prod}, {16'd0, ep});
        check({nm, "_tag"},  {28'd0, res_tag},  {28'd0, et});
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   s0;
        logic seen;

        rst = 1'b0; in_valid = 1'b0; in_v1 = '0; in_v2 = '0; in_tag = '0;
        res_ready = 1'b0; drop_dly = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 1'b1;
        @(posedge clk); #1;

        // Single op and handshake-to-start latency.
        in_v1 = 8'h0C; in_v2 = 8'h0D; in_tag = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_c1_start", {31'd0, mul_start}, 32'd0);
        @(posedge clk); #1;
        check("lat_c2_start", {31'd0, mul_start}, 32'd1);
        check("lat_c2_v1", {24'd0, mul_v1}, 32'h0C);
        check("lat_c2_v2", {24'd0, mul_v2}, 32'h0D);
        @(posedge clk); #1;
        check("start_pulse_end", {31'd0, mul_start}, 32'd0);
        wait_res("single");
        check("single_prod", {16'd0, res_prod}, 32'h009C);
        check("single_tag", {28'd0, res_tag}, 32'd3);
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_prod", {16'd0, res_prod}, 32'h009C);
            check("hold_tag", {28'd0, res_tag}, 32'd3);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("single_done_valid", {31'd0, res_valid}, 32'd0);
        check("single_done_busy", {31'd0, busy}, 32'd0);
        check("single_starts", n_starts, 1);

        // Extreme operand values, order and tags preserved.
        push(8'hFF, 8'hFF, 4'd5);
        push(8'h00, 8'hA5, 4'd9);
        get(16'hFE01, 4'd5, "ext_ff");
        get(16'h0000, 4'd9, "ext_zero");

        // Fill: one op parked in HOLD plus four queued.
        push(8'h01, 8'h02, 4'd1);
        push(8'h03, 8'h04, 4'd2);
        push(8'h10, 8'h10, 4'd3);
        push(8'h7F, 8'h02, 4'd4);
        push(8'h80, 8'h80, 4'd5);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        wait_res("full_op1");
        in_v1 = 8'h11; in_v2 = 8'h0F; in_tag = 4'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        check("full_block", {31'd0, in_ready}, 32'd0);
        check("full_busy", {31'd0, busy}, 32'd1);
        check("full_op1_prod", {16'd0, res_prod}, 32'h0002);
        check("full_op1_tag", {28'd0, res_tag}, 32'd1);
        // Pop while full with an offer pending: in_ready must not react yet.
        res_ready = 1'b1;
        #1;
        check("pop_cycle_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("after_pop_ready", {31'd0, in_ready}, 32'd1);
        check("b2b_start", {31'd0, mul_start}, 32'd1);
        check("after_pop_valid", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("refull_ready", {31'd0, in_ready}, 32'd0);
        get(16'h000C, 4'd2, "drain2");
        get(16'h0100, 4'd3, "drain3");
        get(16'h00FE, 4'd4, "drain4");
        get(16'h4000, 4'd5, "drain5");
        get(16'h00FF, 4'd6, "drain6");
        repeat (5) @(posedge clk);
        #1;
        check("drained_valid", {31'd0, res_valid}, 32'd0);
        check("drained_busy", {31'd0, busy}, 32'd0);
        check("drained_ready", {31'd0, in_ready}, 32'd1);
        check("starts_total", n_starts, 9);

        // Slow multiplier: ready drops three cycles late.
        drop_dly = 3;
        s0 = n_starts;
        push(8'h25, 8'h03, 4'hA);
        get(16'h006F, 4'hA, "slow");
        check("slow_starts", n_starts - s0, 1);
        drop_dly = 0;

        // Reset while BUSY with two entries queued.
        push(8'h21, 8'h02, 4'd1);
        push(8'h22, 8'h02, 4'd2);
        push(8'h23, 8'h02, 4'd3);
        n = 0;
        while (mul_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_mul_low", {31'd0, mul_ready}, 32'd0);
        @(posedge clk); #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_v1", {24'd0, mul_v1}, 32'h21);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid || mul_start) seen = 1'b1;
        end
        check("post_rst_quiet", {31'd0, seen}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_starts", n_starts, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/multiplier_issue_unit.md
# multiplier_issue_unit

Operand-side front end for the 8x8 sequential multiplier. Accepts operand pairs on a valid/ready stream, buffers them in a small FIFO, and drives the multiplier's start/ready handshake one operation at a time. Captures the 16-bit product and returns it with the operand tag on a downstream valid/ready stream. Sits directly upstream of the multiplier top and also collects its result, so the rest of the design never sees the multiplier's start/ready protocol.

## Interface
- DEPTH, 4, operand FIFO entries; power of two, at least 2
- TAG_W, 4, width of the opaque tag carried from operands to result
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); all state clears while low
- in_valid  input  1  operand pair offered
- in_ready  output  1  FIFO can accept; equals "FIFO not full"
- in_v1  input  8  multiplicand
- in_v2  input  8  multiplier
- in_tag  input  TAG_W  tag returned with the product
- mul_start  output  1  start pulse to the multiplier
- mul_v1  output  8  operand to the multiplier, held stable from the start pulse until capture
- mul_v2  output  8  operand to the multiplier, held stable from the start pulse until capture
- mul_ready  input  1  multiplier idle/done flag
- mul_out  input  16  multiplier product
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts the result
- res_prod  output  16  product
- res_tag  output  TAG_W  tag of the product
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty

## Operation
- An input transfer occurs when in_valid and in_ready are both high. The entry {v1, v2, tag} is pushed into the FIFO.
- FIFO structure:
  - Circular buffer; read and write pointers are log2(DEPTH)+1 bits.
  - Full: pointer MSBs differ and the low bits are equal.
  - Empty: the pointers are equal.
  - Pointers wrap modulo 2·DEPTH.
- The FSM has five states:
  - **IDLE**: if the FIFO is non-empty and mul_ready=1, pop the head into operand registers mul_v1/mul_v2/tag and go to ISSUE.
  - **ISSUE**: mul_start=1 for exactly this cycle. Go to ARM.
  - **ARM**: wait for mul_ready=0. Stay while it is 1 (multiplier latency to drop ready), with no timeout.
  - **BUSY**: wait for mul_ready=1. On the cycle it is seen high, load res_prod←mul_out and res_tag←tag, then go to HOLD.
  - **HOLD**: res_valid=1. When res_ready=1, the result is consumed. If the FIFO is non-empty, pop and go to ISSUE directly; otherwise go to IDLE.
- Only one multiplication is in flight at a time. Products are returned in input order.
- A push and a pop in the same cycle are both performed. When the FIFO is full, a simultaneous pop does not raise in_ready combinationally; in_ready depends on registered state only.
- The product is passed through unmodified, with no width change. The tag is not interpreted.
- If rst is asserted mid-operation, the FIFO is emptied, the FSM returns to IDLE, and any in-flight product is discarded. The multiplier shares rst, so both blocks restart together.

## Timing
- Reset values:
  - in_ready=1
  - mul_start=0
  - mul_v1=0 and mul_v2=0
  - res_valid=0
  - res_prod=0 and res_tag=0
  - busy=0
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- Latency from input handshake to mul_start (empty FIFO, idle multiplier, FSM in IDLE):
  - Cycle 0: input handshake.
  - Cycle 1: FSM sees the FIFO non-empty and pops.
  - Cycle 2: mul_start high.
- res_valid rises 1 cycle after mul_ready is sampled high in BUSY.
- Back-to-back throughput: HOLD→ISSUE costs 0 idle cycles, so the next mul_start is asserted in the cycle after the res handshake.
- res_prod and res_tag are stable while res_valid=1 and res_ready=0.

## Structure
- Shared multiplier package holds:
  - the FSM state encoding (IDLE, ISSUE, ARM, BUSY, HOLD), 3 bits;
  - the operand width constant OPW=8 and product width constant PW=16, also used by the multiplier datapath.
- One sub-module, multiplier_operand_fifo: parameterised by DEPTH and data width 16+TAG_W. Exposes push/pop/full/empty and head data.
- The FSM and the result register live in the top of this block.
- Instantiated beside the multiplier top inside the same parent.

## Test plan
- **Single op**: push v1=0x0C, v2=0x0D, tag=3 with a behavioural multiplier model → exactly one mul_start pulse, then res_prod=0x009C, res_tag=3, res_valid held until res_ready.
- **Extreme values**: push 0xFF×0xFF, then 0x00×0xA5 → 0xFE01 then 0x0000, in order, with tags preserved.
- **FIFO full**: hold res_ready=0 and push 6 pairs (DEPTH=4) → in_ready drops after the 5th accept (4 queued plus 1 held in HOLD). No entry is lost or duplicated. Releasing res_ready drains all 5 in order.
- **Simultaneous push/pop at full**: in_ready stays 0 in the pop cycle, rises the next cycle, and the occupancy count is correct.
- **Slow multiplier**: the model delays the drop of mul_ready by 3 cycles → the FSM waits in ARM, issues no second start, and the product is correct.
- **Reset mid-operation**: assert rst low while in BUSY with 2 entries queued → all outputs return to their reset values immediately. After release, busy=0 and no res_valid appears without new input.
